// File: rtl/uarc_receiver_fifo_if.sv
// Handshake bundle between one UARC bus sender (bus_*) and core0's receiver inputs (core_*).
// The slave modport is the receive FIFO. The master modport is whatever drives both sides.
interface uarc_receiver_fifo_if #(
   parameter int WORD_MAG = 5
);
   localparam int WORD_WIDTH = 1 << WORD_MAG;

   logic                  bus_enable;
   logic                  bus_send;
   logic                  bus_stream;
   logic [WORD_WIDTH-1:0] bus_data;
   logic                  bus_send_ack;
   logic                  bus_stream_ack;
   logic                  bus_kill;
   logic                  bus_kill_ack;
   logic                  core_send;
   logic                  core_stream;
   logic [WORD_WIDTH-1:0] core_data;
   logic                  core_send_ack;
   logic                  core_stream_ack;

   modport slave (
      input  bus_enable, bus_send, bus_stream, bus_data, bus_kill,
      input  core_send_ack, core_stream_ack,
      output bus_send_ack, bus_stream_ack, bus_kill_ack,
      output core_send, core_stream, core_data
   );

   modport master (
      output bus_enable, bus_send, bus_stream, bus_data, bus_kill,
      output core_send_ack, core_stream_ack,
      input  bus_send_ack, bus_stream_ack, bus_kill_ack,
      input  core_send, core_stream, core_data
   );
endinterface

// File: rtl/uarc_receiver_fifo.sv
// Per-bus receive FIFO: queues up to DEPTH send/stream words for core0 and presents them
// first-word-fall-through. A remote kill flushes the queue and answers with a one-cycle kill ack.
module uarc_receiver_fifo #(
   parameter int WORD_MAG  = 5,
   parameter int DEPTH_MAG = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   uarc_receiver_fifo_if.slave    bus,
   output logic [DEPTH_MAG:0]     count
);
   localparam int WORD_WIDTH = 1 << WORD_MAG;
   localparam int DEPTH      = 1 << DEPTH_MAG;
   localparam int CNT_W      = DEPTH_MAG + 1;

   typedef enum logic [1:0] {RUN, KILL_ACK, KILL_WAIT} state_e;

   state_e                 state_q, state_d;
   logic [DEPTH_MAG-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_MAG-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   // Each entry is {stream_flag, word}.
   logic [WORD_WIDTH:0]    mem_q [DEPTH];

   logic [WORD_WIDTH:0]    head;
   logic                   full, empty, offer, push, pop;
   logic                   send_ack, stream_ack, kill_ack;
   logic                   core_send, core_stream;
   logic [WORD_WIDTH-1:0]  core_data;

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      offer       = 1'b0;
      send_ack    = 1'b0;
      stream_ack  = 1'b0;
      kill_ack    = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      core_send   = 1'b0;
      core_stream = 1'b0;
      core_data   = '0;

      unique case (state_q)
         RUN: begin
            // Nothing is accepted while reset is held, so no ack can be shown for a word that is dropped.
            offer       = reset && bus.bus_enable && !bus.bus_kill && !full;
            send_ack    = offer && bus.bus_send;
            stream_ack  = offer && bus.bus_stream && !bus.bus_send;
            push        = send_ack || stream_ack;
            core_send   = !empty && !head[WORD_WIDTH];
            core_stream = !empty &&  head[WORD_WIDTH];
            core_data   = head[WORD_WIDTH-1:0];
            pop         = (core_send && bus.core_send_ack) || (core_stream && bus.core_stream_ack);

            if (bus.bus_enable && bus.bus_kill) begin
               state_d  = KILL_ACK;
               rd_ptr_d = wr_ptr_q;
               count_d  = '0;
            end else begin
               if (push) wr_ptr_d = wr_ptr_q + DEPTH_MAG'(1);
               if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_MAG'(1);
               if (push && !pop)      count_d = count_q + CNT_W'(1);
               else if (pop && !push) count_d = count_q - CNT_W'(1);
            end
         end
         KILL_ACK: begin
            kill_ack = 1'b1;
            state_d  = KILL_WAIT;
         end
         KILL_WAIT: begin
            if (!bus.bus_kill) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RUN;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         // NOTE: storage is reset as well so core_data reads 0 out of reset instead of stale words.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push) mem_q[wr_ptr_q] <= {stream_ack, bus.bus_data};
      end
   end

   assign bus.bus_send_ack   = send_ack;
   assign bus.bus_stream_ack = stream_ack;
   assign bus.bus_kill_ack   = kill_ack;
   assign bus.core_send      = core_send;
   assign bus.core_stream    = core_stream;
   assign bus.core_data      = core_data;
   assign count              = count_q;
endmodule

// File: tb/tb_uarc_receiver_fifo.sv
// Self-checking bench for uarc_receiver_fifo: a hand-written step table plus a queue-based reference
// model that predicts acks, head entry and count every cycle.
module tb_uarc_receiver_fifo;
   localparam int DEPTH = 4;

   typedef struct {
      bit        en, send, stream, kill, csa, ssa;
      bit [31:0] data;
      bit        e_sack, e_stack;
      int        e_cnt;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [2:0] count;

   uarc_receiver_fifo_if #(.WORD_MAG(5)) bus_if ();

   uarc_receiver_fifo #(.WORD_MAG(5), .DEPTH_MAG(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [32:0] mq [$];
   int          mst = 0;   // 0 RUN, 1 KILL_ACK, 2 KILL_WAIT
   vec_t        tbl [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit en, bit send, bit stream, bit kill, bit csa, bit ssa,
                               bit [31:0] data, bit e_sack, bit e_stack, int e_cnt);
      vec_t v;
      v.en = en; v.send = send; v.stream = stream; v.kill = kill; v.csa = csa; v.ssa = ssa;
      v.data = data; v.e_sack = e_sack; v.e_stack = e_stack; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus_if.bus_enable      = v.en;
      bus_if.bus_send        = v.send;
      bus_if.bus_stream      = v.stream;
      bus_if.bus_kill        = v.kill;
      bus_if.core_send_ack   = v.csa;
      bus_if.core_stream_ack = v.ssa;
      bus_if.bus_data        = v.data;
   endtask

   // One cycle: drive after the falling edge, compare just after, then advance the model to the next rising edge.
   task automatic step(input vec_t v, input bit use_tbl, input string tag);
      bit        full, offer, esack, estack, ecs, ecst, ekack, pop;
      @(negedge clk);
      drive(v);
      #1;
      full   = (mq.size() == DEPTH);
      offer  = (mst == 0) && v.en && !v.kill && !full;
      esack  = offer && v.send;
      estack = offer && v.stream && !v.send;
      ecs    = (mst == 0) && (mq.size() > 0) && !mq[0][32];
      ecst   = (mst == 0) && (mq.size() > 0) &&  mq[0][32];
      ekack  = (mst == 1);
      check({tag, ".send_ack"},   32'(bus_if.bus_send_ack),   32'(esack));
      check({tag, ".stream_ack"}, 32'(bus_if.bus_stream_ack), 32'(estack));
      check({tag, ".kill_ack"},   32'(bus_if.bus_kill_ack),   32'(ekack));
      check({tag, ".core_send"},  32'(bus_if.core_send),      32'(ecs));
      check({tag, ".core_stream"},32'(bus_if.core_stream),    32'(ecst));
      check({tag, ".count"},      32'(count),                 32'(mq.size()));
      if (ecs || ecst) check({tag, ".core_data"}, bus_if.core_data, mq[0][31:0]);
      if (use_tbl) begin
         check({tag, ".tbl_send_ack"},   32'(bus_if.bus_send_ack),   32'(v.e_sack));
         check({tag, ".tbl_stream_ack"}, 32'(bus_if.bus_stream_ack), 32'(v.e_stack));
         check({tag, ".tbl_count"},      32'(count),                 v.e_cnt);
      end
      pop = (ecs && v.csa) || (ecst && v.ssa);
      case (mst)
         0: begin
            if (v.en && v.kill) begin
               if (pop) void'(mq.pop_front());
               mq.delete();
               mst = 1;
            end else begin
               if (pop) void'(mq.pop_front());
               if (esack || estack) mq.push_back({estack, v.data});
            end
         end
         1: mst = 2;
         default: if (!v.kill) mst = 0;
      endcase
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".send_ack"},    32'(bus_if.bus_send_ack),   0);
      check({tag, ".stream_ack"},  32'(bus_if.bus_stream_ack), 0);
      check({tag, ".kill_ack"},    32'(bus_if.bus_kill_ack),   0);
      check({tag, ".core_send"},   32'(bus_if.core_send),      0);
      check({tag, ".core_stream"}, 32'(bus_if.core_stream),    0);
      check({tag, ".core_data"},   bus_if.core_data,           0);
      check({tag, ".count"},       32'(count),                 0);
   endtask

   vec_t idle;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      //             en s st k csa ssa data          sack stack cnt
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'd1,        1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'd2,        1, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'd3,        1, 0, 2));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'd4,        1, 0, 3));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'd5,        0, 0, 4));
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'd5,        0, 0, 4));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'd5,        1, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 4));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, 32'hA,        0, 1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'hB,        1, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 1, 0, 32'hC,        1, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,        0, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h0,        0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0));

      // Power-on reset with a send offered: nothing may be acked.
      reset = 1'b0;
      drive(mk(1, 1, 0, 0, 0, 0, 32'h55, 0, 0, 0));
      #1;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(idle);
      reset = 1'b1;

      foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

      // Kill with bus_enable low is ignored; then kill mid-queue with a pop on the detect cycle.
      step(mk(1, 1, 0, 0, 0, 0, 32'h11, 0, 0, 0), 1'b0, "kq0");
      step(mk(1, 0, 1, 0, 0, 0, 32'h22, 0, 0, 0), 1'b0, "kq1");
      step(mk(1, 1, 0, 0, 0, 0, 32'h33, 0, 0, 0), 1'b0, "kq2");
      step(mk(0, 0, 0, 1, 0, 0, 32'h0,  0, 0, 0), 1'b0, "kill_dis");
      step(mk(1, 1, 0, 1, 1, 0, 32'h44, 0, 0, 0), 1'b0, "kill_det");
      for (int i = 0; i < 3; i++)
         step(mk(1, 1, 1, 1, 1, 1, 32'h44, 0, 0, 0), 1'b0, $sformatf("kill_hold%0d", i));
      step(mk(1, 1, 0, 0, 0, 0, 32'h44, 0, 0, 0), 1'b0, "kill_drop");
      step(mk(1, 1, 0, 0, 0, 0, 32'h45, 0, 0, 0), 1'b0, "kill_resume");
      step(idle, 1'b0, "kill_head");
      step(mk(0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0), 1'b0, "kill_pop");

      // Sustained push+pop at count 2 across pointer wrap.
      step(mk(1, 1, 0, 0, 0, 0, 32'h100, 0, 0, 0), 1'b0, "wr_a");
      step(mk(1, 0, 1, 0, 0, 0, 32'h101, 0, 0, 0), 1'b0, "wr_b");
      for (int i = 0; i < 10; i++)
         step(mk(1, i[0], !i[0], 0, 1, 1, 32'h102 + i, 0, 0, 0), 1'b0, $sformatf("wrap%0d", i));
      for (int i = 0; i < 3; i++)
         step(mk(0, 0, 0, 0, 1, 1, 32'h0, 0, 0, 0), 1'b0, $sformatf("wr_drain%0d", i));

      // Asynchronous reset between edges with three entries held.
      for (int i = 0; i < 3; i++)
         step(mk(1, 1, 0, 0, 0, 0, 32'h200 + i, 0, 0, 0), 1'b0, $sformatf("ar_fill%0d", i));
      @(negedge clk);
      drive(mk(1, 1, 0, 0, 0, 0, 32'h77, 0, 0, 0));
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      mq.delete();
      mst = 0;
      @(posedge clk);
      @(negedge clk);
      drive(idle);
      reset = 1'b1;
      step(mk(1, 1, 0, 0, 0, 0, 32'h12345678, 0, 0, 0), 1'b0, "post_rst_push");
      step(idle, 1'b0, "post_rst_head");
      step(mk(0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0), 1'b0, "post_rst_pop");
      step(idle, 1'b0, "post_rst_empty");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/uarc_receiver_fifo.md
# uarc_receiver_fifo

Per-bus receive buffer between one UARC bus and the receiver-side inputs of core0 (`receiver_sends`, `receiver_streams`, `receiver_datas`, `receiver_send_acks`, `receiver_stream_acks`, `receiver_kills`). It decouples the remote sender's handshake from the core's interrupt and consume timing. It does this by queueing up to DEPTH send/stream words and handling bus kills locally, with flush and acknowledge. One instance exists per bus; TOTAL_BUSES instances feed core0.

## Interface

Parameters:
- WORD_MAG, 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG
- DEPTH_MAG, 2, log2 of FIFO depth; DEPTH = 1 << DEPTH_MAG

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- bus_enable  in  1  remote sender has this bus selected
- bus_send  in  1  remote offers a send word
- bus_stream  in  1  remote offers a stream word
- bus_data  in  WORD_WIDTH  offered word
- bus_send_ack  out  1  send word accepted this cycle
- bus_stream_ack  out  1  stream word accepted this cycle
- bus_kill  in  1  remote kill request
- bus_kill_ack  out  1  kill acknowledged (1-cycle pulse)
- core_send  out  1  head entry is a send word
- core_stream  out  1  head entry is a stream word
- core_data  out  WORD_WIDTH  head word
- core_send_ack  in  1  core consumes head send word
- core_stream_ack  in  1  core consumes head stream word
- count  out  DEPTH_MAG+1  entries held, 0..DEPTH

## Operation

- Storage: DEPTH entries of {stream_flag, word}; rd_ptr and wr_ptr are DEPTH_MAG bits, wrap mod DEPTH; count is tracked separately; full = (count == DEPTH), empty = (count == 0).
- FSM states: RUN, KILL_ACK, KILL_WAIT.
- In RUN:
  - offer = bus_enable && !bus_kill && !full.
  - bus_send_ack = offer && bus_send.
  - bus_stream_ack = offer && bus_stream && !bus_send. If both are offered, send wins and is stored with flag 0; stream is not acked.
  - push = bus_send_ack || bus_stream_ack. It writes {bus_stream_ack, bus_data} at wr_ptr.
  - Head outputs:
    - core_send = !empty && !head_flag.
    - core_stream = !empty && head_flag.
    - core_data = head word (first-word-fall-through).
  - pop = (core_send && core_send_ack) || (core_stream && core_stream_ack). An ack of the wrong type, or an ack while empty, is ignored.
  - Push while full is impossible, because ack is low. A pop does not free a slot for the same-cycle push.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- RUN → KILL_ACK when bus_enable && bus_kill.
  - At that edge any same-cycle pop is honoured, then all remaining entries are discarded: rd_ptr := wr_ptr, count := 0.
  - No push occurs that cycle.
- KILL_ACK:
  - bus_kill_ack = 1.
  - All send/stream acks and core_send/core_stream are 0.
  - Always → KILL_WAIT next edge.
- KILL_WAIT:
  - All acks and core outputs are 0.
  - → RUN on the edge where bus_kill == 0.
  - bus_enable is ignored.
- bus_kill with bus_enable low is ignored in RUN.
- All outputs are combinational from registered state plus bus/core inputs as stated. Outputs never depend on core_*_ack except through pop.

## Timing

- Reset (reset low, asynchronous):
  - state := RUN; pointers and count := 0.
  - All outputs are 0: bus_*_ack, bus_kill_ack, core_send, core_stream, count. core_data = 0, with storage cleared.
- Reset deasserted mid-transfer: no partial word survives. The first accept is possible on the first edge after release.
- Push latency: a word accepted at edge N is visible on core_send/core_stream/core_data after edge N (same cycle as count increment) when the FIFO was empty.
- Pop latency: the next entry is presented in the cycle after the pop edge.
- Throughput: 1 push + 1 pop per cycle sustained when 0 < count < DEPTH.
- Kill: bus_kill_ack pulses exactly one cycle, the cycle after kill is detected. The minimum kill round trip is 3 cycles: detect, ack, wait with kill low.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no loss of ordering.

## Test plan

- Reset then single send: bus_enable=1, bus_send=1, bus_data=0xDEADBEEF for one cycle.
  - bus_send_ack=1 that cycle.
  - Next cycle: core_send=1, core_data=0xDEADBEEF, count=1.
  - core_send_ack=1 gives count=0 and core_send=0 the following cycle.
- Fill/full with DEPTH=4: push words 1,2,3,4, then offer 5 with no core ack.
  - bus_send_ack=0 for 5; count=4.
  - One pop, then 5 is accepted one cycle later.
  - Drain order is 1,2,3,4,5.
- Stream tagging: push stream 0xA, then send 0xB; also offer both flags simultaneously with 0xC.
  - Head 0xA: core_stream=1, core_send=0. core_send_ack is ignored; core_stream_ack pops it.
  - 0xC is stored as send and bus_stream_ack stays 0.
- Kill mid-queue: 3 entries queued, bus_kill=1 held 4 cycles with core_send_ack=1 on the detect cycle.
  - One entry is popped, and count=0 after the edge.
  - bus_kill_ack=1 for exactly one cycle.
  - No acks while bus_kill stays high.
  - RUN resumes the edge after bus_kill drops.
- Wrap and concurrency: 10 cycles of simultaneous push/pop at count=2.
  - count stays 2 and data order is preserved across pointer wrap.
- Async reset mid-operation: assert reset low between edges with count=3.
  - All outputs are 0 immediately; count=0.
  - The first push after release appears with correct data.
